// File: rtl/buffer_controller.sv
// Text-mode character buffer controller.
// Accepts PUT / CR / LF / CLEAR commands. It tracks the cursor and drives the
// character-buffer write port. The screen scrolls through a rotating start
// address (first_char), so a scroll moves the start address and blanks the
// new bottom row instead of copying the whole buffer.
//
// Ports:
//   clk, clr                  pixel clock, asynchronous active-high reset
//   cmd_valid/cmd_ready       command handshake (ready only while IDLE)
//   cmd_op, cmd_char          command opcode (0=PUT,1=CR,2=LF,3=CLEAR) and PUT data
//   cursor_row, cursor_col    logical cursor position
//   buffer_waddr/din/wen      character buffer write port (registered, wen pulses)
//   buffer_first_char(_wen)   physical address of screen row 0 and its load strobe
module buffer_controller #(
    parameter int unsigned ROWS      = 25,
    parameter int unsigned COLS      = 80,
    parameter int unsigned ROW_BITS  = 5,
    parameter int unsigned COL_BITS  = 7,
    parameter int unsigned ADDR_BITS = 11,
    parameter logic [7:0]  BLANK     = 8'h20
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [7:0]           cmd_char,
    output logic [ROW_BITS-1:0]  cursor_row,
    output logic [COL_BITS-1:0]  cursor_col,
    output logic [ADDR_BITS-1:0] buffer_waddr,
    output logic [7:0]           buffer_din,
    output logic                 buffer_wen,
    output logic [ADDR_BITS-1:0] buffer_first_char,
    output logic                 buffer_first_char_wen
);

    localparam int unsigned SIZE     = ROWS * COLS;
    localparam int unsigned SUM_BITS = 12;
    localparam int unsigned CNT_BITS = 11;

    localparam logic [1:0] OP_PUT   = 2'd0;
    localparam logic [1:0] OP_CR    = 2'd1;
    localparam logic [1:0] OP_LF    = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL_LINE = 2'd1,
        FILL_ALL  = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_BITS-1:0]  first_char, first_char_nxt;
    logic [ROW_BITS-1:0]   row_nxt;
    logic [COL_BITS-1:0]   col_nxt;
    logic [ADDR_BITS-1:0]  waddr_nxt;
    logic [7:0]            din_nxt;
    logic                  wen_nxt;
    logic                  fc_wen_nxt;
    logic [CNT_BITS-1:0]   fill_cnt, fill_cnt_nxt;

    logic [SUM_BITS-1:0]   phys_sum;
    logic [ADDR_BITS-1:0]  phys_addr;
    logic [SUM_BITS-1:0]   scroll_sum;
    logic [ADDR_BITS-1:0]  scroll_fc;
    logic [ADDR_BITS-1:0]  fill_next_addr;
    logic                  fill_last;

    assign cmd_ready         = (state == IDLE);
    assign buffer_first_char = first_char;

    // Physical address of the cursor cell and the start address after one scroll.
    // Both sums stay below 2*SIZE, so a single conditional subtract wraps them.
    always_comb begin
        phys_sum   = SUM_BITS'(first_char)
                   + SUM_BITS'(cursor_row) * SUM_BITS'(COLS)
                   + SUM_BITS'(cursor_col);
        phys_addr  = (phys_sum >= SUM_BITS'(SIZE)) ? ADDR_BITS'(phys_sum - SUM_BITS'(SIZE))
                                                   : ADDR_BITS'(phys_sum);
        scroll_sum = SUM_BITS'(first_char) + SUM_BITS'(COLS);
        scroll_fc  = (scroll_sum >= SUM_BITS'(SIZE)) ? ADDR_BITS'(scroll_sum - SUM_BITS'(SIZE))
                                                     : ADDR_BITS'(scroll_sum);
        fill_next_addr = (buffer_waddr == ADDR_BITS'(SIZE - 1)) ? '0
                                                                : buffer_waddr + ADDR_BITS'(1);
        // fill_cnt is the index of the write currently on the bus.
        fill_last = (state == FILL_LINE) ? (fill_cnt == CNT_BITS'(COLS - 1))
                                         : (fill_cnt == CNT_BITS'(SIZE - 1));
    end

    // State register and all registered outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state                 <= IDLE;
            cursor_row            <= '0;
            cursor_col            <= '0;
            first_char            <= '0;
            buffer_waddr          <= '0;
            buffer_din            <= '0;
            buffer_wen            <= 1'b0;
            buffer_first_char_wen <= 1'b0;
            fill_cnt              <= '0;
        end else begin
            state                 <= state_nxt;
            cursor_row            <= row_nxt;
            cursor_col            <= col_nxt;
            first_char            <= first_char_nxt;
            buffer_waddr          <= waddr_nxt;
            buffer_din            <= din_nxt;
            buffer_wen            <= wen_nxt;
            buffer_first_char_wen <= fc_wen_nxt;
            fill_cnt              <= fill_cnt_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt      = state;
        row_nxt        = cursor_row;
        col_nxt        = cursor_col;
        first_char_nxt = first_char;
        waddr_nxt      = buffer_waddr;
        din_nxt        = buffer_din;
        wen_nxt        = 1'b0;
        fc_wen_nxt     = 1'b0;
        fill_cnt_nxt   = fill_cnt;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    case (cmd_op)
                        OP_PUT: begin
                            wen_nxt   = 1'b1;
                            waddr_nxt = phys_addr;
                            din_nxt   = cmd_char;
                            if (cursor_col != COL_BITS'(COLS - 1)) begin
                                col_nxt = cursor_col + COL_BITS'(1);
                            end
                        end
                        OP_CR: begin
                            col_nxt = '0;
                        end
                        OP_LF: begin
                            if (cursor_row != ROW_BITS'(ROWS - 1)) begin
                                row_nxt = cursor_row + ROW_BITS'(1);
                            end else begin
                                // Old top row becomes the new bottom row; blank it.
                                first_char_nxt = scroll_fc;
                                fc_wen_nxt     = 1'b1;
                                wen_nxt        = 1'b1;
                                waddr_nxt      = first_char;
                                din_nxt        = BLANK;
                                fill_cnt_nxt   = '0;
                                state_nxt      = FILL_LINE;
                            end
                        end
                        OP_CLEAR: begin
                            first_char_nxt = '0;
                            fc_wen_nxt     = 1'b1;
                            row_nxt        = '0;
                            col_nxt        = '0;
                            wen_nxt        = 1'b1;
                            waddr_nxt      = '0;
                            din_nxt        = BLANK;
                            fill_cnt_nxt   = '0;
                            state_nxt      = FILL_ALL;
                        end
                        default: ;
                    endcase
                end
            end
            FILL_LINE, FILL_ALL: begin
                if (fill_last) begin
                    state_nxt = IDLE;
                end else begin
                    wen_nxt      = 1'b1;
                    waddr_nxt    = fill_next_addr;
                    din_nxt      = BLANK;
                    fill_cnt_nxt = fill_cnt + CNT_BITS'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_buffer_controller.sv
// Self-checking bench for buffer_controller: directed scenarios plus random
// commands, compared against a screen-level model (cursor, start address,
// expected write stream) built from plain arithmetic.
module tb_buffer_controller;

    localparam int ROWS  = 25;
    localparam int COLS  = 80;
    localparam int SIZE  = ROWS * COLS;
    localparam logic [7:0] BLANK = 8'h20;

    logic        clk;
    logic        clr;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_char;
    logic [4:0]  cursor_row;
    logic [6:0]  cursor_col;
    logic [10:0] buffer_waddr;
    logic [7:0]  buffer_din;
    logic        buffer_wen;
    logic [10:0] buffer_first_char;
    logic        buffer_first_char_wen;

    buffer_controller dut (
        .clk                   (clk),
        .clr                   (clr),
        .cmd_valid             (cmd_valid),
        .cmd_ready             (cmd_ready),
        .cmd_op                (cmd_op),
        .cmd_char              (cmd_char),
        .cursor_row            (cursor_row),
        .cursor_col            (cursor_col),
        .buffer_waddr          (buffer_waddr),
        .buffer_din            (buffer_din),
        .buffer_wen            (buffer_wen),
        .buffer_first_char     (buffer_first_char),
        .buffer_first_char_wen (buffer_first_char_wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Screen model: logical cursor and physical address of screen row 0.
    int m_row = 0;
    int m_col = 0;
    int m_fc  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_view(input string tag);
        check({tag, "_row"}, 32'(cursor_row), m_row);
        check({tag, "_col"}, 32'(cursor_col), m_col);
        check({tag, "_fc"},  32'(buffer_first_char), m_fc);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wen"},   32'(buffer_wen), 0);
        check({tag, "_waddr"}, 32'(buffer_waddr), 0);
        check({tag, "_din"},   32'(buffer_din), 0);
        check({tag, "_fcwen"}, 32'(buffer_first_char_wen), 0);
        check({tag, "_fc"},    32'(buffer_first_char), 0);
        check({tag, "_row"},   32'(cursor_row), 0);
        check({tag, "_col"},   32'(cursor_col), 0);
    endtask

    task automatic reset_dut();
        clr       = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        clr = 1'b0;
        m_row = 0; m_col = 0; m_fc = 0;
        @(negedge clk);
        check("reset_ready", 32'(cmd_ready), 1);
        check_all_zero("post_reset");
    endtask

    // Called at the negedge of the first fill cycle. Checks n blank writes at
    // base, base+1, ... (mod SIZE). abort_at >= 0 pulses clr at that write index.
    task automatic run_fill(input int base, input int n, input int abort_at);
        for (int i = 0; i < n; i++) begin
            check("fill_wen",   32'(buffer_wen), 1);
            check("fill_waddr", 32'(buffer_waddr), (base + i) % SIZE);
            check("fill_din",   32'(buffer_din), 32'(BLANK));
            check("fill_fcwen", 32'(buffer_first_char_wen), (i == 0) ? 1 : 0);
            check("fill_ready", 32'(cmd_ready), 0);
            check_view("fill");
            if (i == abort_at) begin
                clr       = 1'b1;
                cmd_valid = 1'b0;
                #1;
                check_all_zero("abort");
                check("abort_ready", 32'(cmd_ready), 1);
                @(negedge clk);
                clr = 1'b0;
                m_row = 0; m_col = 0; m_fc = 0;
                @(negedge clk);
                check_all_zero("after_abort");
                return;
            end
            // Commands offered during a fill must be ignored.
            cmd_valid = (i < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            cmd_op    = 2'($urandom);
            cmd_char  = 8'($urandom);
            @(negedge clk);
        end
        check("fill_end_wen",   32'(buffer_wen), 0);
        check("fill_end_fcwen", 32'(buffer_first_char_wen), 0);
        check("fill_end_ready", 32'(cmd_ready), 1);
        check_view("fill_end");
    endtask

    // Offer one command at a negedge and check the cycle after acceptance.
    task automatic send(input logic [1:0] op, input logic [7:0] ch, input int abort_at = -1);
        int addr;
        int base;
        check("send_ready", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_char  = ch;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_char  = 8'($urandom);
        case (op)
            2'd0: begin
                addr = (m_fc + m_row * COLS + m_col) % SIZE;
                check("put_wen",   32'(buffer_wen), 1);
                check("put_waddr", 32'(buffer_waddr), addr);
                check("put_din",   32'(buffer_din), 32'(ch));
                check("put_fcwen", 32'(buffer_first_char_wen), 0);
                if (m_col < COLS - 1) m_col++;
                check_view("put");
                check("put_ready", 32'(cmd_ready), 1);
            end
            2'd1: begin
                m_col = 0;
                check("cr_wen", 32'(buffer_wen), 0);
                check_view("cr");
            end
            2'd2: begin
                if (m_row < ROWS - 1) begin
                    m_row++;
                    check("lf_wen",   32'(buffer_wen), 0);
                    check("lf_fcwen", 32'(buffer_first_char_wen), 0);
                    check_view("lf");
                end else begin
                    base = m_fc;
                    m_fc = (m_fc + COLS) % SIZE;
                    run_fill(base, COLS, abort_at);
                end
            end
            default: begin
                m_fc = 0; m_row = 0; m_col = 0;
                run_fill(0, SIZE, abort_at);
            end
        endcase
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        check("idle_wen",   32'(buffer_wen), 0);
        check("idle_fcwen", 32'(buffer_first_char_wen), 0);
        check_view("idle");
    endtask

    initial begin
        int r;
        clr       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_char  = 8'h00;

        reset_dut();

        // First PUT after reset lands at address 0.
        send(2'd0, 8'h41);
        idle_cycle();

        // Fill row 0 and overrun the last column.
        for (int i = 0; i < 80; i++) send(2'd0, 8'(8'h30 + (i % 40)));
        send(2'd1, 8'h00);
        idle_cycle();

        // Walk to the bottom row, then scroll 25 times (start address wraps).
        for (int i = 0; i < 24; i++) send(2'd2, 8'h00);
        for (int i = 0; i < 25; i++) send(2'd2, 8'h00);
        check("wrap_fc", 32'(buffer_first_char), 0);

        send(2'd1, 8'h00);
        for (int i = 0; i < 5; i++) send(2'd0, 8'h2e);
        send(2'd0, 8'h5a);
        check("row24_col5_addr", 32'(buffer_waddr), 1925);

        // Full clear.
        send(2'd3, 8'h00);
        idle_cycle();

        // Random command mix.
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      send(2'd0, 8'($urandom));
            else if (r < 65) send(2'd1, 8'($urandom));
            else if (r < 96) send(2'd2, 8'($urandom));
            else if (r < 97) send(2'd3, 8'($urandom));
            else             idle_cycle();
        end

        // Reset in the middle of a scroll fill (write 40).
        reset_dut();
        for (int i = 0; i < 24; i++) send(2'd2, 8'h00);
        send(2'd2, 8'h00, 39);
        send(2'd0, 8'h78);
        check("abort_put_addr", 32'(buffer_waddr), 0);
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
